fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Instruction-memory read channel between the fetch stage and instruction memory.
//   mem_req   : read request, held until mem_ready (fetch -> memory)
//   mem_addr  : read address, stable while mem_req=1 (fetch -> memory)
//   mem_ready : mem_rdata is valid this cycle (memory -> fetch)
//   mem_rdata : instruction word (memory -> fetch)
// Modports: master = fetch side, slave = memory side.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage of the multicycle CPU, directly upstream of the IR.
// Holds the PC, issues read requests on the memory channel, presents the
// fetched word with its PC and strobes the IR load enable. Handles branch
// redirection (including while a request is outstanding) and stall.
// Ports:
//   clk, reset      : clock; synchronous active-high reset
//   mem             : instruction-memory channel (fetch_unit_if.master)
//   stall           : downstream cannot accept an instruction this cycle
//   branch_taken    : single-cycle redirect pulse
//   branch_target   : redirect PC (bits [1:0] forced to zero)
//   instr, instr_pc : fetched word and its address (IR d input)
//   instr_valid     : instr/instr_pc hold an unconsumed instruction
//   ir_enable       : IR load strobe (combinational)
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_unit_if.master          mem,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic                  ir_enable
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  valid_q, valid_d;
    logic                  redirect_pending_q, redirect_pending_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    // Instructions are word aligned: the low two target bits are dropped.
    logic [ADDR_WIDTH-1:0] target_aligned;
    assign target_aligned = branch_target & ~ADDR_WIDTH'(3);

    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        instr_d            = instr_q;
        instr_pc_d         = instr_pc_q;
        valid_d            = valid_q;
        redirect_pending_d = redirect_pending_q;
        redirect_pc_d      = redirect_pc_q;

        case (state_q)
            IDLE: begin
                if (branch_taken) begin
                    pc_d    = target_aligned;
                    valid_d = 1'b0;
                end
                state_d = FETCH;
            end
            FETCH: begin
                if (mem.mem_ready) begin
                    if (branch_taken) begin
                        // A branch arriving with the data is the most recent
                        // redirect, so it overrides any pending one.
                        pc_d               = target_aligned;
                        redirect_pending_d = 1'b0;
                    end else if (redirect_pending_q) begin
                        pc_d               = redirect_pc_q;
                        redirect_pending_d = 1'b0;
                    end else begin
                        instr_d    = mem.mem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + ADDR_WIDTH'(PC_STEP);
                        state_d    = HOLD;
                    end
                end else if (branch_taken) begin
                    // The request cannot be withdrawn; remember where to go
                    // once the wrong-path data has been discarded.
                    redirect_pending_d = 1'b1;
                    redirect_pc_d      = target_aligned;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_d    = target_aligned;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            pc_q               <= RESET_PC;
            instr_q            <= '0;
            instr_pc_q         <= '0;
            valid_q            <= 1'b0;
            redirect_pending_q <= 1'b0;
            redirect_pc_q      <= '0;
        end else begin
            state_q            <= state_d;
            pc_q               <= pc_d;
            instr_q            <= instr_d;
            instr_pc_q         <= instr_pc_d;
            valid_q            <= valid_d;
            redirect_pending_q <= redirect_pending_d;
            redirect_pc_q      <= redirect_pc_d;
        end
    end

    assign mem.mem_req  = (state_q == FETCH);
    assign mem.mem_addr = pc_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign instr_valid  = valid_q;
    // A branch in the same cycle flushes the held word instead of loading it.
    assign ir_enable    = valid_q & ~stall & ~branch_taken;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] instr, instr_pc;
    logic        instr_valid, ir_enable;

    fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();

    fetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .PC_STEP   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem          (mif),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .ir_enable    (ir_enable)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } ir_t;

    ir_t exp_q[$];
    ir_t got_log[$];
    ir_t mon_e;

    // Reference model: what the IR should see, tracked per fetch phase.
    localparam int P_IDLE = 0, P_FETCH = 1, P_HOLD = 2;
    int          m_phase;
    logic [31:0] m_pc, m_instr, m_ipc, m_rpc;
    logic        m_valid, m_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic st, input logic br, input logic [31:0] tgt,
                                input logic rdy, input logic rst, input logic [31:0] rd);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        if (rst) begin
            m_phase = P_IDLE; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
            m_valid = 1'b0;   m_pend = 1'b0; m_rpc = 32'h0;
        end else if (m_phase == P_IDLE) begin
            if (br) begin m_pc = t; m_valid = 1'b0; end
            m_phase = P_FETCH;
        end else if (m_phase == P_FETCH) begin
            if (rdy) begin
                if (br) begin
                    m_pc = t; m_pend = 1'b0;
                end else if (m_pend) begin
                    m_pc = m_rpc; m_pend = 1'b0;
                end else begin
                    m_instr = rd; m_ipc = m_pc; m_valid = 1'b1;
                    m_pc = m_pc + 32'd4; m_phase = P_HOLD;
                end
            end else if (br) begin
                m_pend = 1'b1; m_rpc = t;
            end
        end else begin
            if (br) begin
                m_pc = t; m_valid = 1'b0; m_phase = P_FETCH;
            end else if (!st) begin
                m_valid = 1'b0; m_phase = P_FETCH;
            end
        end
    endtask

    // Monitor: every IR load must match the oldest expected instruction.
    always @(negedge clk) begin
        if (ir_enable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ir_load_unexpected: got load of pc %h expected no load", instr_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if (instr !== mon_e.data || instr_pc !== mon_e.pc) begin
                    failures++;
                    $display("FAIL ir_load: got %h@%h expected %h@%h", instr, instr_pc, mon_e.data, mon_e.pc);
                end
                got_log.push_back({instr, instr_pc});
            end
        end
    end

    // One clock cycle: check registered outputs, apply inputs, predict.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                        input logic rdy, input logic rst, input logic rnd);
        logic [31:0] rd;
        logic        exp_ire;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL ir_load_missing: got no load expected %0d pending", exp_q.size());
            exp_q.delete();
        end
        check("mem_req", 32'(mif.mem_req), 32'(m_phase == P_FETCH));
        if (m_phase == P_FETCH) check("mem_addr", mif.mem_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_ipc);
        rd = rnd ? $urandom : (m_pc ^ 32'hDEAD_0000);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        mif.mem_ready = rdy;
        mif.mem_rdata = rd;
        reset         = rst;
        #1;
        exp_ire = m_valid && !st && !br;
        check("ir_enable", 32'(ir_enable), 32'(exp_ire));
        if (exp_ire) exp_q.push_back({m_instr, m_ipc});
        model_update(st, br, tgt, rdy, rst, rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;
        @(posedge clk);
        #1;
        model_update(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);

        // Reset, free-run, stall while holding 0xDEAD_0004
        step(0, 0, 0, 1, 1, 0);
        check("reset_mem_req", 32'(mif.mem_req), 32'd0);
        step(0, 0, 0, 1, 0, 0);
        check("req_after_idle", 32'(mif.mem_req), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        repeat (5) step(1, 0, 0, 1, 0, 0);
        check("stall_instr", instr, 32'hDEAD_0004);
        step(0, 0, 0, 1, 0, 0);
        check("addr_after_stall", mif.mem_addr, 32'h0000_0008);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("log_size", got_log.size(), 32'd3);
        if (got_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("log_pc", got_log[i].pc, 32'(4 * i));
                check("log_data", got_log[i].data, 32'hDEAD_0000 + 32'(4 * i));
            end
        end

        // Branch with data in FETCH, then slow memory with branch in the wait
        step(0, 1, 32'h0000_0010, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_0103, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("addr_held", mif.mem_addr, 32'h0000_0010);
        step(0, 0, 0, 1, 0, 0);
        check("redirect_addr", mif.mem_addr, 32'h0000_0100);
        check("redirect_valid", 32'(instr_valid), 32'd0);

        // Branch in HOLD with stall=0 the same cycle
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 32'h0000_0040, 1, 0, 0);
        check("flush_valid", 32'(instr_valid), 32'd0);
        check("flush_addr", mif.mem_addr, 32'h0000_0040);

        // Wrap-around
        step(0, 1, 32'hFFFF_FFFC, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 0, 0);
        check("wrap_addr", mif.mem_addr, 32'h0000_0000);

        // Reset mid-request, late mem_ready ignored
        step(0, 1, 32'h0000_0020, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("rst_mid_req", 32'(mif.mem_req), 32'd0);
        check("rst_mid_addr", mif.mem_addr, 32'h0000_0000);
        step(0, 0, 0, 1, 0, 0);
        check("restart_addr", mif.mem_addr, 32'h0000_0000);
        step(0, 0, 0, 1, 0, 0);
        check("restart_pc", instr_pc, 32'h0000_0000);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            step(($urandom % 3) == 0, ($urandom % 6) == 0, $urandom,
                 ($urandom % 2) == 0, ($urandom % 64) == 0, 1'b1);
        end
        step(0, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
